// File: rtl/fifo_pkg.sv
// Shared defaults and elaboration helpers for the async FIFO read side.
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;

  // Width needed to hold a count from 0 up to and including depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // The credit scheme needs at least one slot beyond the words in flight.
  function automatic bit depth_ok(input int depth, input int lat);
    return depth >= lat + 1;
  endfunction
endpackage

// File: rtl/rd_lat_pipe.sv
// Valid shift register tracking accepted pops until their memory data returns.
module rd_lat_pipe #(
  parameter int Latency = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_vld,
  output logic [Latency-1:0] vld_pipe
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      for (int i = 1; i < Latency; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end
endmodule

// File: rtl/rd_fwft_stage.sv
// FWFT output stage: issues pops against a credit limit and buffers the
// returning memory data in a small circular buffer.
module rd_fwft_stage
  import fifo_pkg::*;
#(
  parameter int Data_Width   = DATA_WIDTH_DEF,
  parameter int Read_Latency = 1,
  parameter int Out_Depth    = 3
) (
  input  logic                            rd_clk,
  input  logic                            rd_rstn,
  input  logic                            fifo_empty,
  output logic                            fifo_rd_en,
  input  logic [Data_Width-1:0]           mem_rdata,
  output logic [Data_Width-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [cnt_w(Out_Depth)-1:0]     out_count
);
  localparam int CW = cnt_w(Out_Depth);
  localparam int RW = CW + 2;
  localparam int PW = (Out_Depth > 1) ? $clog2(Out_Depth) : 1;

  generate
    if (!depth_ok(Out_Depth, Read_Latency)) begin : g_bad_depth
      $error("rd_fwft_stage: Out_Depth must be >= Read_Latency+1");
    end
  endgenerate

  logic                    rst_done;
  logic [Read_Latency-1:0] vld_pipe;
  logic [RW-1:0]           reserved;
  logic                    pop, cap, cons;
  logic [PW-1:0]           head, tail;
  logic [Data_Width-1:0]   dbuf [Out_Depth];

  rd_lat_pipe #(.Latency(Read_Latency)) u_lat_pipe (
    .clk      (rd_clk),
    .rstn     (rd_rstn),
    .in_vld   (pop),
    .vld_pipe (vld_pipe)
  );

  // Credits count both buffered words and words still inside the memory read.
  always_comb begin
    reserved = RW'(out_count);
    for (int i = 0; i < Read_Latency; i++) reserved = reserved + RW'(vld_pipe[i]);
  end

  assign fifo_rd_en = rst_done & (reserved < RW'(Out_Depth));
  assign pop        = fifo_rd_en & ~fifo_empty;
  assign cap        = vld_pipe[Read_Latency-1];
  assign out_valid  = (out_count != '0);
  assign cons       = out_valid & out_ready;
  assign out_data   = dbuf[head];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(Out_Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      rst_done  <= 1'b0;
      head      <= '0;
      tail      <= '0;
      out_count <= '0;
      for (int i = 0; i < Out_Depth; i++) dbuf[i] <= '0;
    end else begin
      rst_done <= 1'b1;
      if (cap) begin
        dbuf[tail] <= mem_rdata;
        tail       <= nxt(tail);
      end
      if (cons) head <= nxt(head);
      if (cap && !cons)      out_count <= out_count + CW'(1);
      else if (cons && !cap) out_count <= out_count - CW'(1);
    end
  end
endmodule

// File: tb/tb_rd_fwft_stage.sv
// Randomized bench for rd_fwft_stage against a queue-based timing model.
module tb_rd_fwft_stage;
  localparam int DW = 8;
  localparam int L  = 1;
  localparam int D  = 3;

  logic          rd_clk = 1'b0;
  logic          rd_rstn = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [1:0]    out_count;

  rd_fwft_stage #(.Data_Width(DW), .Read_Latency(L), .Out_Depth(D)) dut (
    .rd_clk(rd_clk), .rd_rstn(rd_rstn), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .mem_rdata(mem_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count)
  );

  always #5 rd_clk = ~rd_clk;

  typedef struct { logic [DW-1:0] d; int vis; } ent_t;
  ent_t q[$];
  int   cyc_n = 0;
  bit   rst_done = 0;
  bit   seq_mode = 0;
  logic [DW-1:0] word_next = '0;
  int   errs = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  // Words become visible one cycle after the memory returns them.
  function automatic int vis_cnt();
    int n = 0;
    foreach (q[i]) if (q[i].vis <= cyc_n) n++;
    return n;
  endfunction

  task automatic cyc(input bit emp, input bit rdy);
    bit exp_rden, exp_vld, pop, cons;
    int vc;
    fifo_empty = emp;
    out_ready  = rdy;
    #1;
    vc       = vis_cnt();
    exp_vld  = (vc != 0);
    exp_rden = rst_done && (q.size() < D);
    chk("rd_en", 32'(fifo_rd_en), 32'(exp_rden));
    chk("valid", 32'(out_valid), 32'(exp_vld));
    chk("count", 32'(out_count), 32'(vc));
    chk("no_ovf", 32'(q.size() <= D), 32'd1);
    if (exp_vld) chk("data", 32'(out_data), 32'(q[0].d));
    pop  = exp_rden && !emp;
    cons = exp_vld && rdy;
    @(posedge rd_clk);
    cyc_n++;
    rst_done = 1;
    if (cons) void'(q.pop_front());
    if (pop) begin
      ent_t e;
      e.d = word_next;
      e.vis = cyc_n + L;
      q.push_back(e);
    end
    #1;
    if (pop) begin
      mem_rdata = word_next;
      word_next = seq_mode ? word_next + 8'd1 : DW'($urandom);
    end
    @(negedge rd_clk);
  endtask

  task automatic reset_hold(input int n);
    rd_rstn = 1'b0;
    #1;
    q.delete();
    rst_done = 0;
    for (int i = 0; i <= n; i++) begin
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(out_count), 32'd0);
      chk("rst_data", 32'(out_data), 32'd0);
      if (i < n) @(negedge rd_clk);
    end
    rd_rstn = 1'b1;
  endtask

  initial begin
    // Reset with a non-empty FIFO: no requests until the first edge after release.
    fifo_empty = 1'b0;
    @(negedge rd_clk);
    reset_hold(3);
    cyc(1, 0);

    // Single word, held under backpressure.
    word_next = 8'hA5;
    cyc(0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0);
    cyc(1, 1);
    cyc(1, 0);

    // Backpressure fill then drain in order.
    seq_mode = 1;
    word_next = 8'd1;
    for (int i = 0; i < 6; i++) cyc(0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1);

    // Streaming with random data across pointer wrap.
    seq_mode = 0;
    word_next = DW'($urandom);
    for (int i = 0; i < 20; i++) cyc(0, 1);

    // Empty toggling with random consumer.
    for (int i = 0; i < 60; i++) cyc(i[0], 1'($urandom));

    // Mid-operation reset with two buffered words and one in flight.
    for (int i = 0; i < 4; i++) cyc(1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0);
    chk("pre_rst_count", 32'(out_count), 32'd2);
    #2;
    reset_hold(2);
    for (int i = 0; i < 3; i++) cyc(1, 0);

    // Fully random traffic.
    for (int i = 0; i < 300; i++) cyc(1'($urandom_range(0, 3) == 0), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rd_fwft_stage.md
Name: rd_fwft_stage

Overview:
- Read-side output stage of the asynchronous FIFO, in the read clock domain, directly downstream of the read-pointer block.
- Drives the read-pointer block's rd_en and consumes its empty flag plus the synchronous memory read data.
- Presents a first-word-fall-through valid/ready stream to the consumer, and hides memory read latency with a small credit-managed output buffer.

Parameters:
- Data_Width, 8, width of memory read data and of the output stream.
- Read_Latency, 1, cycles from an accepted pop to mem_rdata valid (legal 1..3).
- Out_Depth, 3, output buffer entries. Legal range is Out_Depth >= Read_Latency+1; Out_Depth >= Read_Latency+2 gives full throughput.

Ports:
- rd_clk  input  1  read-domain clock.
- rd_rstn  input  1  asynchronous active-low reset.
- fifo_empty  input  1  registered empty flag from the read-pointer block.
- fifo_rd_en  output  1  pop request to the read-pointer block.
- mem_rdata  input  Data_Width  memory read data, valid Read_Latency cycles after an accepted pop.
- out_data  output  Data_Width  head-of-buffer data.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the word this cycle.
- out_count  output  $clog2(Out_Depth+1)  words currently held in the buffer.

Behaviour:
- Clock and reset: single clock rd_clk; reset rd_rstn is asynchronous and active-low.
- Reset values: out_valid=0, out_count=0, out_data=0, in-flight pipe cleared, rst_done=0.
- rst_done is a flag that goes 1 on the first rd_clk edge after reset release. fifo_rd_en=0 while rst_done=0.
- Pop accepted = fifo_rd_en & !fifo_empty. Only accepted pops enter a Read_Latency-deep in-flight valid shift register.
- reserved = out_count + number of in-flight valid bits. Both terms are registered.
- fifo_rd_en = rst_done & (reserved < Out_Depth). It has no combinational path from out_ready or fifo_empty.
  - fifo_rd_en may be high while fifo_empty=1. Such a request is not a pop and reserves nothing.
- Capture: when the in-flight pipe's last stage is valid, mem_rdata is written at the buffer tail that cycle.
  - Overflow is impossible by construction; a bench assertion must check this.
- Pop to consumer: happens when out_valid & out_ready. The head advances at the clock edge.
- out_valid = (out_count != 0). It is registered-state derived; FWFT means out_data shows the head word with no request needed.
- Simultaneous capture and consume: out_count unchanged, and both pointers advance.
  - If the buffer is empty, a captured word appears on out_data the cycle after capture. There is no same-cycle bypass.
- Buffer is circular. Head/tail pointers wrap modulo Out_Depth, which need not be a power of 2; wrap explicitly at Out_Depth-1.
- out_count range is 0..Out_Depth. Increment on capture only, decrement on consume only.
- Latency: accepted pop at cycle N → mem_rdata captured at N+Read_Latency → out_valid high at N+Read_Latency+1.
- Throughput: with Out_Depth >= Read_Latency+2 and out_ready held high, one word per cycle is sustained after fill.
- Ordering: words leave in exactly the order pops were accepted.
- out_ready while out_valid=0: ignored.
- out_data while out_valid=0: don't-care; must not be X after reset (cleared to 0).
- Reset mid-operation: all buffered and in-flight words are discarded immediately. The read-pointer block resets on the same rd_rstn, so pointers stay consistent.
- Does not check or re-synchronise fifo_empty. fifo_empty is a same-domain registered signal.

Decomposition:
- fifo_pkg holds:
  - default Data_Width.
  - localparam function for the count width, clog2(Out_Depth+1).
  - a lint-level check that Out_Depth >= Read_Latency+1.
- Optional sub-module rd_lat_pipe: the Read_Latency-deep valid shift register with async reset. Everything else stays in rd_fwft_stage.

Test Plan:
- Reset: hold rd_rstn low 3 cycles with fifo_empty=0 → fifo_rd_en=0, out_valid=0, out_count=0; fifo_rd_en rises 1 cycle after release.
- Single word: fifo_empty=0 for exactly 1 accepted pop, mem_rdata=8'hA5 one cycle later, out_ready=0 → out_valid=1 at pop+2, out_data=8'hA5, out_count=1, held until out_ready.
- Backpressure fill: fifo_empty=0, out_ready=0, data 1,2,3,... → exactly 3 pops accepted, out_count=3, fifo_rd_en=0 afterwards. Release out_ready → words 1,2,3,4,... in order with no loss or duplicate.
- Streaming: fifo_empty=0, out_ready=1 for 20 cycles → after fill, out_valid stays high every cycle; 1 word/cycle; data sequence matches pop order across pointer wrap.
- Empty interplay: toggle fifo_empty 1/0 every cycle with random out_ready → every pop with fifo_empty=1 is ignored; scoreboard order exact; out_count never exceeds 3.
- Mid-operation reset: assert rd_rstn with out_count=2 and 1 word in flight → outputs return to reset values asynchronously; no stale word appears after release.
